// File: rtl/cobs_frame_arbiter_if.sv
// cobs_frame_arbiter_if
//   Bundles the NUM_SRC AXI-Stream producer inputs and the single output
//   stream toward the COBS encoder.
//   slave  : arbiter side (consumes s_*, drives m_*)
//   master : environment side (drives s_* and m_tready)
//   s_tdata  NUM_SRC*DATA_WIDTH  source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid/s_tlast/s_tready    one bit per source
//   m_tdata/m_tvalid/m_tlast/m_tid/m_tready  merged output stream
interface cobs_frame_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 16
);
    localparam int TID_W = $clog2(NUM_SRC);

    logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_SRC-1:0]            s_tvalid;
    logic [NUM_SRC-1:0]            s_tlast;
    logic [NUM_SRC-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]         m_tdata;
    logic                          m_tvalid;
    logic                          m_tlast;
    logic [TID_W-1:0]              m_tid;
    logic                          m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );
endinterface

// File: rtl/cobs_frame_arbiter.sv
// cobs_frame_arbiter
//   Frame-granular round-robin arbiter feeding one COBS encoder input from
//   NUM_SRC AXI-Stream sources. A granted source keeps the output until its
//   tlast beat is accepted, or until MAX_FRAME_BEATS beats have passed, in
//   which case the frame is closed early and the source's trunc_err bit set.
//   Ports:
//     clk        clock
//     rst        asynchronous active-low reset
//     bus        cobs_frame_arbiter_if.slave (sources in, encoder stream out)
//     trunc_err  sticky per-source truncation flags
//     trunc_clr  clears trunc_err (a truncation in the same cycle still sets)
//
//   state | meaning
//   IDLE  | no owner; pick next requester after last_grant (1-cycle bubble)
//   GRANT | grant owns the output until its frame-ending beat is accepted
module cobs_frame_arbiter #(
    parameter int NUM_SRC         = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_FRAME_BEATS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    cobs_frame_arbiter_if.slave   bus,
    output logic [NUM_SRC-1:0]    trunc_err,
    input  logic                  trunc_clr
);
    localparam int TID_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAME_BEATS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state;
    logic [TID_W-1:0]      grant;
    logic [TID_W-1:0]      last_grant;
    logic [TID_W-1:0]      pick;
    logic [TID_W-1:0]      rr_idx;
    logic                  found;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  out_free;
    logic                  accept;
    logic                  end_beat;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    // Walk candidates from farthest to nearest so the nearest requester
    // after last_grant is the one left standing.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_idx = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            rr_idx = TID_W'((int'(last_grant) + i) % NUM_SRC);
            if (bus.s_tvalid[rr_idx]) begin
                found = 1'b1;
                pick  = rr_idx;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == TID_W'(i)) begin
                sel_valid = bus.s_tvalid[i];
                sel_last  = bus.s_tlast[i];
                sel_data  = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output register can take a beat when empty or draining this cycle.
    assign out_free = !bus.m_tvalid || bus.m_tready;
    assign accept   = (state == GRANT) && sel_valid && out_free;
    assign end_beat = sel_last || (beat_cnt == CNT_LAST);

    always_comb begin
        bus.s_tready = '0;
        if (state == GRANT) begin
            bus.s_tready[grant] = out_free;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= TID_W'(NUM_SRC - 1);
            beat_cnt     <= '0;
            trunc_err    <= '0;
            bus.m_tdata  <= '0;
            bus.m_tvalid <= 1'b0;
            bus.m_tlast  <= 1'b0;
            bus.m_tid    <= '0;
        end else begin
            if (trunc_clr) begin
                trunc_err <= '0;
            end

            if (accept) begin
                bus.m_tdata  <= sel_data;
                bus.m_tid    <= grant;
                bus.m_tvalid <= 1'b1;
                bus.m_tlast  <= end_beat;
            end else if (bus.m_tready) begin
                bus.m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        if (end_beat) begin
                            beat_cnt   <= '0;
                            last_grant <= grant;
                            state      <= IDLE;
                            // Later assignment overrides the clear above.
                            if (!sel_last) begin
                                trunc_err[grant] <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cobs_frame_arbiter.sv
// tb_cobs_frame_arbiter
//   Directed bench for cobs_frame_arbiter (NUM_SRC=4, DATA_WIDTH=16,
//   MAX_FRAME_BEATS=4). Per-source beat queues feed the sources; beats
//   accepted by the encoder side are collected as {tid, last, data}.
module tb_cobs_frame_arbiter;
    localparam int NUM_SRC = 4;
    localparam int DW      = 16;
    localparam int MAXB    = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               trunc_clr = 1'b0;
    logic [NUM_SRC-1:0] trunc_err;

    cobs_frame_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW)) bus ();

    cobs_frame_arbiter #(
        .NUM_SRC(NUM_SRC),
        .DATA_WIDTH(DW),
        .MAX_FRAME_BEATS(MAXB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .trunc_err(trunc_err),
        .trunc_clr(trunc_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0]        sq [NUM_SRC][$];
    logic [18:0]        obs [$];
    logic [NUM_SRC-1:0] take;
    logic               rdy_fixed  = 1'b1;
    logic               rdy_pat_en = 1'b0;
    logic [15:0]        rdy_pat    = 16'b0110_1001_1100_0101;
    int                 cyc        = 0;
    logic               stall_prev = 1'b0;
    logic [18:0]        held;
    int                 stall_cnt  = 0;
    int                 stall_viol = 0;

    task automatic drive();
        logic [16:0] f;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sq[i].size() > 0) begin
                f = sq[i][0];
                bus.s_tvalid[i]          = 1'b1;
                bus.s_tlast[i]           = f[16];
                bus.s_tdata[i*DW +: DW]  = f[15:0];
            end else begin
                bus.s_tvalid[i]          = 1'b0;
                bus.s_tlast[i]           = 1'b0;
                bus.s_tdata[i*DW +: DW]  = '0;
            end
        end
        bus.m_tready = rdy_pat_en ? rdy_pat[4'(cyc)] : rdy_fixed;
    endtask

    // One clock: sample at negedge, then update stimulus 1ns after posedge.
    task automatic step();
        logic [18:0] cur;
        @(negedge clk);
        cur = {bus.m_tid, bus.m_tlast, bus.m_tdata};
        for (int i = 0; i < NUM_SRC; i++) begin
            take[i] = bus.s_tvalid[i] && bus.s_tready[i];
        end
        if (stall_prev && (!bus.m_tvalid || cur !== held)) stall_viol++;
        if (bus.m_tvalid && !bus.m_tready) begin
            stall_cnt++;
            held       = cur;
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
        if (bus.m_tvalid && bus.m_tready) obs.push_back(cur);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (take[i]) void'(sq[i].pop_front());
        end
        drive();
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (obs.size() >= n);
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NUM_SRC; i++) sq[i].delete();
        obs.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_queues();
        drive();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        sq[2].push_back({1'b1, 16'hDEAD});
        drive();
        step();
        step();
        n_checks++;
        if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", bus.m_tvalid); end
        n_checks++;
        if (bus.m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast: got %b expected 0", bus.m_tlast); end
        n_checks++;
        if (bus.m_tdata !== 16'h0) begin n_fail++; $display("FAIL reset_m_tdata: got %h expected 0000", bus.m_tdata); end
        n_checks++;
        if (bus.m_tid !== 2'd0) begin n_fail++; $display("FAIL reset_m_tid: got %0d expected 0", bus.m_tid); end
        n_checks++;
        if (bus.s_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_s_tready: got %b expected 0000", bus.s_tready); end
        n_checks++;
        if (trunc_err !== 4'b0000) begin n_fail++; $display("FAIL reset_trunc_err: got %b expected 0000", trunc_err); end
        clear_queues();
        drive();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit got = 1'b0;
        logic [18:0] e = {2'd0, 1'b1, 16'h6971};
        sq[0].push_back({1'b1, 16'h6971});
        drive();
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = take[0];
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL single_accept: got no accept expected accept within 10 cycles"); end
        step();
        n_checks++;
        if (obs.size() != 1) begin
            n_fail++; $display("FAIL single_latency: got %0d beats expected 1 one cycle after accept", obs.size());
        end else if (obs[0] !== e) begin
            n_fail++; $display("FAIL single_beat: got %h expected %h", obs[0], e);
        end
        step();
        step();
        obs.delete();
    endtask

    task automatic test_two_frames();
        logic [18:0] exp [$];
        bit ok;
        sq[1].push_back({1'b0, 16'h1101});
        sq[1].push_back({1'b1, 16'h1102});
        sq[2].push_back({1'b0, 16'h2201});
        sq[2].push_back({1'b1, 16'h2202});
        exp.push_back({2'd1, 1'b0, 16'h1101});
        exp.push_back({2'd1, 1'b1, 16'h1102});
        exp.push_back({2'd2, 1'b0, 16'h2201});
        exp.push_back({2'd2, 1'b1, 16'h2202});
        drive();
        run_until(4, 40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL two_frames_timeout: got %0d beats expected 4", obs.size()); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= obs.size()) begin
                n_fail++; $display("FAIL two_frames beat %0d: got none expected %h", k, exp[k]);
            end else if (obs[k] !== exp[k]) begin
                n_fail++; $display("FAIL two_frames beat %0d: got %h expected %h", k, obs[k], exp[k]);
            end
        end
        step();
        step();
        step();
        n_checks++;
        if (obs.size() != 4) begin n_fail++; $display("FAIL two_frames_count: got %0d beats expected 4", obs.size()); end
        obs.delete();
    endtask

    task automatic test_round_robin();
        logic [18:0] e;
        bit ok;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                sq[i].push_back({1'b1, 16'h3000 + 16'(i*16 + r)});
            end
        end
        drive();
        run_until(8, 60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d beats expected 8", obs.size()); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                e = {2'(i), 1'b1, 16'h3000 + 16'(i*16 + r)};
                n_checks++;
                if (r*4 + i >= obs.size()) begin
                    n_fail++; $display("FAIL rr beat %0d: got none expected %h", r*4 + i, e);
                end else if (obs[r*4 + i] !== e) begin
                    n_fail++; $display("FAIL rr beat %0d: got %h expected %h", r*4 + i, obs[r*4 + i], e);
                end
            end
        end
        step();
        step();
        obs.delete();
    endtask

    task automatic test_truncation();
        logic [18:0] e;
        bit ok;
        for (int k = 0; k < 6; k++) sq[3].push_back({(k == 5), 16'h4400 + 16'(k)});
        drive();
        run_until(6, 60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL trunc_timeout: got %0d beats expected 6", obs.size()); end
        for (int k = 0; k < 6; k++) begin
            e = {2'd3, (k == 3 || k == 5), 16'h4400 + 16'(k)};
            n_checks++;
            if (k >= obs.size()) begin
                n_fail++; $display("FAIL trunc beat %0d: got none expected %h", k, e);
            end else if (obs[k] !== e) begin
                n_fail++; $display("FAIL trunc beat %0d: got %h expected %h", k, obs[k], e);
            end
        end
        step();
        n_checks++;
        if (trunc_err !== 4'b1000) begin n_fail++; $display("FAIL trunc_err_set: got %b expected 1000", trunc_err); end
        trunc_clr = 1'b1;
        step();
        trunc_clr = 1'b0;
        n_checks++;
        if (trunc_err !== 4'b0000) begin n_fail++; $display("FAIL trunc_err_clr: got %b expected 0000", trunc_err); end
        step();
        obs.delete();
    endtask

    task automatic test_exact_max();
        logic [18:0] e;
        bit ok;
        for (int k = 0; k < MAXB; k++) sq[1].push_back({(k == MAXB-1), 16'h5500 + 16'(k)});
        drive();
        run_until(MAXB, 40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL exact_timeout: got %0d beats expected %0d", obs.size(), MAXB); end
        for (int k = 0; k < MAXB; k++) begin
            e = {2'd1, (k == MAXB-1), 16'h5500 + 16'(k)};
            n_checks++;
            if (k >= obs.size()) begin
                n_fail++; $display("FAIL exact beat %0d: got none expected %h", k, e);
            end else if (obs[k] !== e) begin
                n_fail++; $display("FAIL exact beat %0d: got %h expected %h", k, obs[k], e);
            end
        end
        step();
        n_checks++;
        if (trunc_err !== 4'b0000) begin n_fail++; $display("FAIL exact_trunc_err: got %b expected 0000", trunc_err); end
        obs.delete();
    endtask

    task automatic test_stall();
        logic [18:0] e;
        bit ok;
        stall_prev = 1'b0;
        stall_cnt  = 0;
        stall_viol = 0;
        rdy_pat_en = 1'b1;
        for (int k = 0; k < 3; k++) sq[0].push_back({(k == 2), 16'h7700 + 16'(k)});
        drive();
        run_until(3, 80, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout: got %0d beats expected 3", obs.size()); end
        for (int k = 0; k < 3; k++) begin
            e = {2'd0, (k == 2), 16'h7700 + 16'(k)};
            n_checks++;
            if (k >= obs.size()) begin
                n_fail++; $display("FAIL stall beat %0d: got none expected %h", k, e);
            end else if (obs[k] !== e) begin
                n_fail++; $display("FAIL stall beat %0d: got %h expected %h", k, obs[k], e);
            end
        end
        for (int k = 0; k < 6; k++) step();
        n_checks++;
        if (obs.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d beats expected 3", obs.size()); end
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable stall cycles expected 0", stall_viol); end
        rdy_pat_en = 1'b0;
        drive();
        step();
        obs.delete();
    endtask

    task automatic test_reset_midframe();
        logic [18:0] e;
        bit ok;
        for (int k = 0; k < 3; k++) sq[0].push_back({(k == 2), 16'h8800 + 16'(k)});
        drive();
        run_until(1, 20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midrst_first_beat: got %0d beats expected 1", obs.size()); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_tvalid: got %b expected 0", bus.m_tvalid); end
        n_checks++;
        if (bus.s_tready !== 4'b0000) begin n_fail++; $display("FAIL midrst_s_tready: got %b expected 0000", bus.s_tready); end
        clear_queues();
        drive();
        step();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (obs.size() != 0) begin n_fail++; $display("FAIL midrst_flush: got %0d beats expected 0", obs.size()); end
        for (int k = 0; k < 3; k++) sq[0].push_back({(k == 2), 16'h9900 + 16'(k)});
        drive();
        run_until(3, 40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midrst_timeout: got %0d beats expected 3", obs.size()); end
        for (int k = 0; k < 3; k++) begin
            e = {2'd0, (k == 2), 16'h9900 + 16'(k)};
            n_checks++;
            if (k >= obs.size()) begin
                n_fail++; $display("FAIL midrst beat %0d: got none expected %h", k, e);
            end else if (obs[k] !== e) begin
                n_fail++; $display("FAIL midrst beat %0d: got %h expected %h", k, obs[k], e);
            end
        end
        step();
        obs.delete();
    endtask

    initial begin
        take = '0;
        held = '0;
        drive();
        test_reset();
        test_single();
        test_two_frames();
        test_round_robin();
        test_truncation();
        test_exact_max();
        test_stall();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
